// File: rtl/poly_pkg.sv
`default_nettype none
// ============================================================================
// Module   : poly_pkg
// Purpose  : Shared widths, command encodings and error bit positions for the
//            polynomial operand store.
// Revision : 1.0 - initial release
// ============================================================================
package poly_pkg;

    localparam int CW     = 16;                 // coefficient / x word width
    localparam int NSETS  = 8;                  // coefficient sets
    localparam int AW     = $clog2(NSETS);      // set address width
    localparam int MAXC   = 32;                 // coefficients per set
    localparam int NW     = $clog2(MAXC);       // degree / index width
    localparam int XDEPTH = 32;                 // x FIFO depth
    localparam int XCW    = $clog2(XDEPTH) + 1; // occupancy width (0..XDEPTH)
    localparam int EW     = 3;                  // error vector width

    typedef enum logic [1:0] {
        OP_WR_COEF = 2'b00,
        OP_WR_N    = 2'b01,
        OP_PUSH_X  = 2'b10,
        OP_CLR_SET = 2'b11
    } cmd_op_t;

    localparam int ERR_UFL   = 0;  // pop from empty x FIFO
    localparam int ERR_EMPTY = 1;  // degree read of an empty set
    localparam int ERR_IDX   = 2;  // coefficient read past c_0

endpackage
`default_nettype wire

// File: rtl/poly_operand_store_if.sv
`default_nettype none
// ============================================================================
// Module   : poly_operand_store_if
// Purpose  : Valid/ready command port used to load coefficient sets and push
//            evaluation points into the operand store.
// Revision : 1.0 - initial release
// ============================================================================
interface poly_operand_store_if;
    import poly_pkg::*;

    logic          cmd_valid;
    logic          cmd_ready;
    cmd_op_t       cmd_op;
    logic [AW-1:0] cmd_A;
    logic [NW-1:0] cmd_idx;
    logic [CW-1:0] cmd_data;

    modport master (
        output cmd_valid, cmd_op, cmd_A, cmd_idx, cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_A, cmd_idx, cmd_data,
        output cmd_ready
    );
endinterface
`default_nettype wire

// File: rtl/x_fifo.sv
`default_nettype none
// ============================================================================
// Module   : x_fifo
// Purpose  : Synchronous FIFO of evaluation points with registered read data,
//            occupancy count and a combinational underflow indication.
// Revision : 1.0 - initial release
// ============================================================================
module x_fifo #(
    parameter int DW    = 16,
    parameter int DEPTH = 32
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    input  wire logic                   i_push,
    input  wire logic [DW-1:0]          i_push_data,
    input  wire logic                   i_pop,
    output logic      [DW-1:0]          o_rd_data,
    output logic      [$clog2(DEPTH):0] o_count,
    output logic                        o_underflow
);
    localparam int PW = $clog2(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic          w_do_pop;

    // A pop on an empty FIFO never bypasses a same-cycle push.
    assign o_underflow = i_pop && (o_count == '0);
    assign w_do_pop    = i_pop && (o_count != '0);

    // Storage array; contents are don't-care while unoccupied.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_push_data;
    end

    // Pointers, occupancy and the registered head value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            o_count   <= '0;
            o_rd_data <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop) begin
                r_rd_ptr  <= r_rd_ptr + 1'b1;
                o_rd_data <= r_mem[r_rd_ptr];
            end else if (i_pop) begin
                o_rd_data <= '0;
            end
            case ({i_push, w_do_pop})
                2'b10:   o_count <= o_count + 1'b1;
                2'b01:   o_count <= o_count - 1'b1;
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/poly_operand_store.sv
`default_nettype none
// ============================================================================
// Module   : poly_operand_store
// Purpose  : Holds eight coefficient sets and a FIFO of x values, loaded via a
//            command port and read by the batch evaluator one operand/cycle.
// Revision : 1.0 - initial release
// ============================================================================
module poly_operand_store
    import poly_pkg::*;
(
    input  wire logic            clk,
    input  wire logic            rst,
    poly_operand_store_if.slave  cmd,
    input  wire logic            busy,
    input  wire logic [AW-1:0]   rd_A,
    input  wire logic            en_rd_N,
    input  wire logic            en_rd_S,
    input  wire logic            en_rd_data,
    output logic      [NW-1:0]   N,
    output logic      [CW-1:0]   c_i,
    output logic      [CW-1:0]   x_b,
    output logic      [XCW-1:0]  x_count,
    output logic      [EW-1:0]   err,
    input  wire logic            clr_err
);
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_d;
    logic          w_cmd_ready;
    logic          w_accept;
    logic          w_sweep_en;
    logic [NW-1:0] r_sweep;
    logic [AW-1:0] r_clr_set;

    logic [CW-1:0] r_coef [NSETS][MAXC];
    logic [NW-1:0] r_n    [NSETS];
    logic [NSETS-1:0] r_set_valid;
    logic [NW-1:0] r_ptr;
    logic          r_ptr_done;   // last coefficient already delivered

    logic          w_push;
    logic          w_x_underflow;
    logic [EW-1:0] w_err_set;

    // Control FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_d;
    end

    // Next state and command acceptance; nothing is accepted during a sweep.
    always_comb begin
        w_state_d   = r_state;
        w_cmd_ready = 1'b0;
        w_sweep_en  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cmd.cmd_op == OP_PUSH_X)
                    w_cmd_ready = (x_count != XCW'(XDEPTH));
                else
                    w_cmd_ready = !(busy && (cmd.cmd_A == rd_A));
                w_cmd_ready = w_cmd_ready && rst;
                if (cmd.cmd_valid && w_cmd_ready && (cmd.cmd_op == OP_CLR_SET))
                    w_state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                w_sweep_en = 1'b1;
                if (r_sweep == NW'(MAXC - 1)) w_state_d = ST_IDLE;
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    assign cmd.cmd_ready = w_cmd_ready;
    assign w_accept      = cmd.cmd_valid && w_cmd_ready;
    assign w_push        = w_accept && (cmd.cmd_op == OP_PUSH_X);

    // Sweep index over the set being cleared.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)            r_sweep <= '0;
        else if (w_sweep_en) r_sweep <= r_sweep + 1'b1;
        else                 r_sweep <= '0;
    end

    // Coefficient array: command writes and the clear sweep.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < NSETS; s++)
                for (int k = 0; k < MAXC; k++)
                    r_coef[s][k] <= '0;
        end else begin
            if (w_accept && (cmd.cmd_op == OP_WR_COEF))
                r_coef[cmd.cmd_A][cmd.cmd_idx] <= cmd.cmd_data;
            if (w_sweep_en)
                r_coef[r_clr_set][r_sweep] <= '0;
        end
    end

    // Per-set degree, valid flag and the set chosen for clearing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < NSETS; s++) r_n[s] <= '0;
            r_set_valid <= '0;
            r_clr_set   <= '0;
        end else if (w_accept) begin
            case (cmd.cmd_op)
                OP_WR_COEF: r_set_valid[cmd.cmd_A] <= 1'b1;
                OP_WR_N: begin
                    r_n[cmd.cmd_A]         <= cmd.cmd_data[NW-1:0];
                    r_set_valid[cmd.cmd_A] <= 1'b1;
                end
                OP_CLR_SET: begin
                    r_n[cmd.cmd_A]         <= '0;
                    r_set_valid[cmd.cmd_A] <= 1'b0;
                    r_clr_set              <= cmd.cmd_A;
                end
                default: ;
            endcase
        end
    end

    // Read side: degree, Horner-order coefficient pointer and outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            N          <= '0;
            c_i        <= '0;
            r_ptr      <= '0;
            r_ptr_done <= 1'b0;
        end else begin
            if (en_rd_S) c_i <= r_coef[rd_A][r_ptr];
            if (en_rd_N) begin
                N          <= r_n[rd_A];
                r_ptr      <= r_n[rd_A];
                r_ptr_done <= 1'b0;
            end else if (en_rd_S) begin
                if (r_ptr == '0) r_ptr_done <= 1'b1;
                else             r_ptr      <= r_ptr - 1'b1;
            end
        end
    end

    always_comb begin
        w_err_set            = '0;
        w_err_set[ERR_UFL]   = w_x_underflow;
        w_err_set[ERR_EMPTY] = en_rd_N && !r_set_valid[rd_A];
        w_err_set[ERR_IDX]   = en_rd_S && r_ptr_done;
    end

    // Sticky error flags; a new event beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) err <= '0;
        else      err <= (clr_err ? '0 : err) | w_err_set;
    end

    x_fifo #(
        .DW    (CW),
        .DEPTH (XDEPTH)
    ) u_x_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (cmd.cmd_data),
        .i_pop       (en_rd_data),
        .o_rd_data   (x_b),
        .o_count     (x_count),
        .o_underflow (w_x_underflow)
    );
endmodule
`default_nettype wire

// File: tb/tb_poly_operand_store.sv
`default_nettype none
// ============================================================================
// Module   : tb_poly_operand_store
// Purpose  : Self-checking bench for poly_operand_store with directed
//            scenarios and a randomized run against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_poly_operand_store;
    import poly_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        busy = 1'b0;
    logic [2:0]  rd_A = '0;
    logic        en_rd_N = 1'b0, en_rd_S = 1'b0, en_rd_data = 1'b0, clr_err = 1'b0;
    logic [4:0]  N;
    logic [15:0] c_i, x_b;
    logic [5:0]  x_count;
    logic [2:0]  err;

    int n_cmp = 0;
    int n_fail = 0;

    poly_operand_store_if ifc ();

    poly_operand_store dut (
        .clk        (clk),
        .rst        (rst),
        .cmd        (ifc),
        .busy       (busy),
        .rd_A       (rd_A),
        .en_rd_N    (en_rd_N),
        .en_rd_S    (en_rd_S),
        .en_rd_data (en_rd_data),
        .N          (N),
        .c_i        (c_i),
        .x_b        (x_b),
        .x_count    (x_count),
        .err        (err),
        .clr_err    (clr_err)
    );

    always #5 clk = ~clk;

    // Behavioural model of the store.
    logic [15:0] m_coef [8][32];
    logic [4:0]  m_n [8];
    bit          m_valid [8];
    logic [15:0] xq [$];
    logic [4:0]  m_N, m_ptr;
    bit          m_done;
    logic [15:0] m_ci, m_xb;
    logic [2:0]  m_err;
    int          m_clear_left;
    bit          m_acc;

    task automatic model_reset();
        for (int s = 0; s < 8; s++) begin
            m_n[s] = '0; m_valid[s] = 0;
            for (int k = 0; k < 32; k++) m_coef[s][k] = '0;
        end
        xq.delete();
        m_N = '0; m_ptr = '0; m_done = 0; m_ci = '0; m_xb = '0; m_err = '0;
        m_clear_left = 0; m_acc = 0;
    endtask

    function automatic bit model_ready();
        if (!rst || m_clear_left > 0) return 1'b0;
        if (ifc.cmd_op == OP_PUSH_X) return xq.size() < 32;
        return !(busy && ifc.cmd_A == rd_A);
    endfunction

    // Advance one clock; update the model from the inputs present before the edge.
    task automatic step();
        bit acc;
        logic [2:0] eset;
        acc  = ifc.cmd_valid && model_ready();
        eset = '0;
        @(posedge clk);
        if (en_rd_S) begin
            m_ci = m_coef[rd_A][m_ptr];
            if (m_done) eset[2] = 1'b1;
        end
        if (en_rd_N) begin
            m_N = m_valid[rd_A] ? m_n[rd_A] : 5'd0;
            if (!m_valid[rd_A]) eset[1] = 1'b1;
            m_ptr = m_N; m_done = 0;
        end else if (en_rd_S) begin
            if (m_ptr == 0) m_done = 1; else m_ptr = m_ptr - 5'd1;
        end
        if (en_rd_data) begin
            if (xq.size() == 0) begin m_xb = '0; eset[0] = 1'b1; end
            else m_xb = xq.pop_front();
        end
        if (m_clear_left > 0) m_clear_left--;
        if (acc) begin
            case (ifc.cmd_op)
                OP_WR_COEF: begin m_coef[ifc.cmd_A][ifc.cmd_idx] = ifc.cmd_data; m_valid[ifc.cmd_A] = 1; end
                OP_WR_N:    begin m_n[ifc.cmd_A] = ifc.cmd_data[4:0]; m_valid[ifc.cmd_A] = 1; end
                OP_PUSH_X:  xq.push_back(ifc.cmd_data);
                default: begin
                    m_n[ifc.cmd_A] = '0; m_valid[ifc.cmd_A] = 0; m_clear_left = 32;
                    for (int k = 0; k < 32; k++) m_coef[ifc.cmd_A][k] = '0;
                end
            endcase
        end
        m_err = (clr_err ? 3'b000 : m_err) | eset;
        m_acc = acc;
        #1;
        en_rd_N = 0; en_rd_S = 0; en_rd_data = 0; clr_err = 0;
    endtask

    task automatic do_cmd(input cmd_op_t op, input logic [2:0] a, input logic [4:0] idx, input logic [15:0] d);
        ifc.cmd_valid = 1; ifc.cmd_op = op; ifc.cmd_A = a; ifc.cmd_idx = idx; ifc.cmd_data = d;
        for (int i = 0; i < 100; i++) begin
            step();
            if (m_acc) break;
        end
        if (!m_acc) begin n_cmp++; n_fail++; $display("FAIL cmd_timeout op=%0d A=%0d never accepted", op, a); end
        ifc.cmd_valid = 0;
    endtask

    task automatic test_reset();
        ifc.cmd_valid = 1; ifc.cmd_op = OP_WR_N; ifc.cmd_A = 0; ifc.cmd_idx = 0; ifc.cmd_data = 16'h1234;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (N !== 5'd0)        begin n_fail++; $display("FAIL rst_N got %0d want 0", N); end
        n_cmp++; if (c_i !== 16'd0)     begin n_fail++; $display("FAIL rst_c_i got %h want 0", c_i); end
        n_cmp++; if (x_b !== 16'd0)     begin n_fail++; $display("FAIL rst_x_b got %h want 0", x_b); end
        n_cmp++; if (x_count !== 6'd0)  begin n_fail++; $display("FAIL rst_x_count got %0d want 0", x_count); end
        n_cmp++; if (err !== 3'd0)      begin n_fail++; $display("FAIL rst_err got %b want 000", err); end
        n_cmp++; if (ifc.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL rst_cmd_ready got %b want 0", ifc.cmd_ready); end
        ifc.cmd_valid = 0;
        rst = 1;
        model_reset();
    endtask

    task automatic test_load_read();
        do_cmd(OP_WR_N, 3'd2, 5'd0, 16'd3);
        for (int k = 0; k < 4; k++) do_cmd(OP_WR_COEF, 3'd2, 5'(k), 16'(k + 1));
        rd_A = 2; en_rd_N = 1; step();
        n_cmp++; if (N !== 5'd3) begin n_fail++; $display("FAIL load_N got %0d want 3", N); end
        for (int k = 0; k < 4; k++) begin
            en_rd_S = 1; step();
            n_cmp++; if (c_i !== 16'(4 - k)) begin n_fail++; $display("FAIL load_c_i[%0d] got %0d want %0d", k, c_i, 4 - k); end
        end
        n_cmp++; if (err !== 3'b000) begin n_fail++; $display("FAIL load_err got %b want 000", err); end
        en_rd_S = 1; step();
        n_cmp++; if (c_i !== 16'd1 || err !== 3'b100) begin n_fail++; $display("FAIL past_c0 got c_i=%0d err=%b want 1/100", c_i, err); end
        step();
        n_cmp++; if (c_i !== 16'd1) begin n_fail++; $display("FAIL hold_c_i got %0d want 1", c_i); end
        clr_err = 1; step();
        n_cmp++; if (err !== 3'b000) begin n_fail++; $display("FAIL clr_err got %b want 000", err); end
    endtask

    task automatic test_fifo_full();
        for (int i = 0; i < 32; i++) do_cmd(OP_PUSH_X, 3'd0, 5'd0, 16'(16'h0010 + i));
        n_cmp++; if (x_count !== 6'd32) begin n_fail++; $display("FAIL full_count got %0d want 32", x_count); end
        ifc.cmd_valid = 1; ifc.cmd_op = OP_PUSH_X; ifc.cmd_data = 16'h0030;
        #1;
        n_cmp++; if (ifc.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got %b want 0", ifc.cmd_ready); end
        en_rd_data = 1; step();
        n_cmp++; if (x_b !== 16'h0010 || x_count !== 6'd31) begin n_fail++; $display("FAIL pop_at_full got x_b=%h cnt=%0d want 0010/31", x_b, x_count); end
        #1;
        n_cmp++; if (ifc.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_pop got %b want 1", ifc.cmd_ready); end
        en_rd_data = 1; step();
        ifc.cmd_valid = 0;
        n_cmp++; if (x_b !== 16'h0011 || x_count !== 6'd31) begin n_fail++; $display("FAIL push_pop got x_b=%h cnt=%0d want 0011/31", x_b, x_count); end
        do_cmd(OP_PUSH_X, 3'd0, 5'd0, 16'h0031);
        n_cmp++; if (x_count !== 6'd32) begin n_fail++; $display("FAIL refill_count got %0d want 32", x_count); end
        for (int i = 0; i < 32; i++) begin
            en_rd_data = 1; step();
            n_cmp++; if (x_b !== 16'(16'h0012 + i)) begin n_fail++; $display("FAIL drain[%0d] got %h want %h", i, x_b, 16'h0012 + i); end
        end
        n_cmp++; if (x_count !== 6'd0) begin n_fail++; $display("FAIL drained_count got %0d want 0", x_count); end
    endtask

    task automatic test_underflow();
        en_rd_data = 1; step();
        n_cmp++; if (x_b !== 16'd0 || err !== 3'b001) begin n_fail++; $display("FAIL underflow got x_b=%h err=%b want 0/001", x_b, err); end
        n_cmp++; if (x_count !== 6'd0) begin n_fail++; $display("FAIL underflow_count got %0d want 0", x_count); end
        en_rd_data = 1; clr_err = 1; step();
        n_cmp++; if (err !== 3'b001) begin n_fail++; $display("FAIL set_beats_clr got %b want 001", err); end
        clr_err = 1; step();
        n_cmp++; if (err !== 3'b000) begin n_fail++; $display("FAIL clr_underflow got %b want 000", err); end
    endtask

    task automatic test_busy_protect();
        busy = 1; rd_A = 2;
        ifc.cmd_valid = 1; ifc.cmd_op = OP_WR_COEF; ifc.cmd_A = 2; ifc.cmd_idx = 1; ifc.cmd_data = 16'hBEEF;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (ifc.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL busy_block[%0d] got %b want 0", i, ifc.cmd_ready); end
            step();
        end
        busy = 0; #1;
        n_cmp++; if (ifc.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL busy_release got %b want 1", ifc.cmd_ready); end
        step();
        busy = 1; ifc.cmd_A = 3; ifc.cmd_idx = 0; ifc.cmd_data = 16'h3333; #1;
        n_cmp++; if (ifc.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL other_set got %b want 1", ifc.cmd_ready); end
        step();
        ifc.cmd_valid = 0; busy = 0;
        rd_A = 2; en_rd_N = 1; step();
        for (int k = 0; k < 3; k++) begin en_rd_S = 1; step(); end
        n_cmp++; if (c_i !== 16'hBEEF) begin n_fail++; $display("FAIL busy_write_landed got %h want beef", c_i); end
    endtask

    task automatic test_clear_set();
        int lows;
        do_cmd(OP_CLR_SET, 3'd2, 5'd0, 16'd0);
        ifc.cmd_valid = 1; ifc.cmd_op = OP_WR_N; ifc.cmd_A = 5; ifc.cmd_data = 16'd7;
        lows = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (ifc.cmd_ready) break;
            lows++;
            step();
        end
        step();
        ifc.cmd_valid = 0;
        n_cmp++; if (lows !== 32) begin n_fail++; $display("FAIL clear_ready_low got %0d cycles want 32", lows); end
        rd_A = 2; en_rd_N = 1; step();
        n_cmp++; if (N !== 5'd0 || err !== 3'b010) begin n_fail++; $display("FAIL cleared_N got N=%0d err=%b want 0/010", N, err); end
        en_rd_S = 1; step();
        n_cmp++; if (c_i !== 16'd0) begin n_fail++; $display("FAIL cleared_c_i got %h want 0", c_i); end
        clr_err = 1; step();
        do_cmd(OP_WR_N, 3'd2, 5'd0, 16'd3);
        en_rd_N = 1; step();
        for (int k = 0; k < 4; k++) begin
            en_rd_S = 1; step();
            n_cmp++; if (c_i !== 16'd0) begin n_fail++; $display("FAIL sweep_zero[%0d] got %h want 0", k, c_i); end
        end
        rd_A = 3; en_rd_N = 1; step();
        en_rd_S = 1; step();
        n_cmp++; if (N !== 5'd0 || c_i !== 16'h3333 || err !== 3'b000) begin
            n_fail++; $display("FAIL set3_intact got N=%0d c_i=%h err=%b want 0/3333/000", N, c_i, err);
        end
        rd_A = 5; en_rd_N = 1; step();
        n_cmp++; if (N !== 5'd7) begin n_fail++; $display("FAIL held_cmd got N=%0d want 7", N); end
    endtask

    task automatic test_reset_mid_clear();
        for (int i = 0; i < 6; i++) do_cmd(OP_PUSH_X, 3'd0, 5'd0, 16'(16'h0A00 + i));
        en_rd_data = 1; step();
        do_cmd(OP_CLR_SET, 3'd3, 5'd0, 16'd0);
        repeat (10) step();
        ifc.cmd_valid = 1; ifc.cmd_op = OP_WR_N; ifc.cmd_A = 0; ifc.cmd_data = 16'd9;
        #2; rst = 0; #1;
        n_cmp++; if (x_count !== 6'd0 || x_b !== 16'd0 || N !== 5'd0 || c_i !== 16'd0 || err !== 3'd0 || ifc.cmd_ready !== 1'b0) begin
            n_fail++; $display("FAIL mid_rst got cnt=%0d x_b=%h N=%0d c_i=%h err=%b rdy=%b want all 0", x_count, x_b, N, c_i, err, ifc.cmd_ready);
        end
        repeat (2) @(posedge clk);
        #1; rst = 1; model_reset(); #1;
        n_cmp++; if (ifc.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL idle_after_rst got %b want 1", ifc.cmd_ready); end
        step();
        ifc.cmd_valid = 0;
        rd_A = 2; en_rd_N = 1; step();
        n_cmp++; if (N !== 5'd0 || err !== 3'b010 || x_count !== 6'd0) begin
            n_fail++; $display("FAIL post_rst_state got N=%0d err=%b cnt=%0d want 0/010/0", N, err, x_count);
        end
    endtask

    task automatic test_random();
        int r;
        for (int i = 0; i < 1000; i++) begin
            ifc.cmd_valid = ($urandom_range(0, 9) < 6);
            r = $urandom_range(0, 63);
            if (r == 0)       ifc.cmd_op = OP_CLR_SET;
            else if (r <= 20) ifc.cmd_op = OP_WR_COEF;
            else if (r <= 32) ifc.cmd_op = OP_WR_N;
            else              ifc.cmd_op = OP_PUSH_X;
            ifc.cmd_A    = 3'($urandom_range(0, 7));
            ifc.cmd_idx  = 5'($urandom_range(0, 31));
            ifc.cmd_data = 16'($urandom);
            busy       = ($urandom_range(0, 3) == 0);
            rd_A       = 3'($urandom_range(0, 7));
            en_rd_N    = ($urandom_range(0, 4) == 0);
            en_rd_S    = (m_clear_left == 0) && ($urandom_range(0, 9) < 4);
            en_rd_data = ($urandom_range(0, 9) < 3);
            clr_err    = ($urandom_range(0, 9) == 0);
            #1;
            n_cmp++; if (ifc.cmd_ready !== model_ready()) begin n_fail++; $display("FAIL rnd_ready[%0d] got %b want %b", i, ifc.cmd_ready, model_ready()); end
            step();
            n_cmp++; if (N !== m_N)     begin n_fail++; $display("FAIL rnd_N[%0d] got %0d want %0d", i, N, m_N); end
            n_cmp++; if (c_i !== m_ci)  begin n_fail++; $display("FAIL rnd_c_i[%0d] got %h want %h", i, c_i, m_ci); end
            n_cmp++; if (x_b !== m_xb)  begin n_fail++; $display("FAIL rnd_x_b[%0d] got %h want %h", i, x_b, m_xb); end
            n_cmp++; if (x_count !== 6'(xq.size())) begin n_fail++; $display("FAIL rnd_x_count[%0d] got %0d want %0d", i, x_count, xq.size()); end
            n_cmp++; if (err !== m_err) begin n_fail++; $display("FAIL rnd_err[%0d] got %b want %b", i, err, m_err); end
        end
        ifc.cmd_valid = 0;
    endtask

    initial begin
        ifc.cmd_valid = 0; ifc.cmd_op = OP_WR_COEF; ifc.cmd_A = '0; ifc.cmd_idx = '0; ifc.cmd_data = '0;
        model_reset();
        test_reset();
        test_load_read();
        test_fifo_full();
        test_underflow();
        test_busy_protect();
        test_clear_set();
        test_reset_mid_clear();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
